// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch stage. Owns the PC, drives the word-aligned byte address
//               into a combinational instruction ROM and registers the
//               returned word into the IF/ID pipeline register. Handles
//               stall, downstream redirect, early J-type redirect and a
//               sticky fault on out-of-range or misaligned fetch addresses.
// Ports       : clk, rst_n           clock / async active-low reset
//               imem_addr, imem_data instruction memory request / response
//               stall                hold PC and IF/ID
//               redirect_valid/target flush and refetch from target
//               ifid_valid/instr/pc/pc_plus4  IF/ID pipeline register
//               fetch_fault          sticky illegal-fetch flag
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic        fetch_fault
);

    // Upper bound held at 33 bits so 4*IMEM_WORDS == 2^32 still compares cleanly.
    localparam logic [32:0] c_pc_limit = 33'(4 * IMEM_WORDS);
    localparam logic [5:0]  c_op_j     = 6'b000010;

    logic [31:0] r_pc;
    logic        r_ifid_valid;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc_plus4;
    logic        r_fault;

    logic [31:0] w_pc_plus4;
    logic        w_pc_legal;
    logic        w_is_jump;
    logic [31:0] w_jump_target;

    // pc+4 wraps modulo 2^32; a wrap to 0 is caught by the range check
    // because the PC would only reach it after passing the upper limit.
    assign w_pc_plus4    = r_pc + 32'd4;
    assign w_pc_legal    = (r_pc[1:0] == 2'b00) && ({1'b0, r_pc} < c_pc_limit);
    assign w_is_jump     = (imem_data[31:26] == c_op_j);
    assign w_jump_target = {w_pc_plus4[31:28], imem_data[25:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= RESET_PC;
            r_ifid_valid    <= 1'b0;
            r_ifid_instr    <= 32'h0;
            r_ifid_pc       <= 32'h0;
            r_ifid_pc_plus4 <= 32'h0;
            r_fault         <= 1'b0;
        end else if (r_fault) begin
            // Fetching halted: PC frozen, bubbles flow unless decode is stalled.
            if (!stall) begin
                r_ifid_valid <= 1'b0;
            end
        end else if (redirect_valid) begin
            // Redirect overrides stall: the stalled instruction is being flushed.
            r_pc         <= redirect_target;
            r_ifid_valid <= 1'b0;
        end else if (stall) begin
            // Hold everything.
        end else if (!w_pc_legal) begin
            r_fault      <= 1'b1;
            r_ifid_valid <= 1'b0;
        end else begin
            r_ifid_valid    <= 1'b1;
            r_ifid_instr    <= imem_data;
            r_ifid_pc       <= r_pc;
            r_ifid_pc_plus4 <= w_pc_plus4;
            // J is resolved here; the word still goes to decode as a no-op.
            r_pc            <= w_is_jump ? w_jump_target : w_pc_plus4;
        end
    end

    assign imem_addr     = r_pc;
    assign ifid_valid    = r_ifid_valid;
    assign ifid_instr    = r_ifid_instr;
    assign ifid_pc       = r_ifid_pc;
    assign ifid_pc_plus4 = r_ifid_pc_plus4;
    assign fetch_fault   = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch with a
//               combinational 1024-word instruction ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    logic [31:0] rom [0:1023];

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_WORDS (1024)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .ifid_valid      (ifid_valid),
        .ifid_instr      (ifid_instr),
        .ifid_pc         (ifid_pc),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .fetch_fault     (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 32'h1000) ? rom[imem_addr[11:2]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; sample and drive on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [31:0] next_addr);
        chk({tag, "_valid"}, {31'h0, ifid_valid}, 32'h1);
        chk({tag, "_pc"}, ifid_pc, pc);
        chk({tag, "_pc4"}, ifid_pc_plus4, pc + 32'd4);
        chk({tag, "_instr"}, ifid_instr, instr);
        chk({tag, "_addr"}, imem_addr, next_addr);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
        rom[0] = 32'h8c01_0001;  // LW
        rom[1] = 32'h8c02_0002;  // LW
        rom[2] = 32'h0022_1820;  // ADD
        rom[3] = 32'hac03_0003;  // SW
        rom[4] = 32'h2004_0004;
        rom[5] = 32'h2005_0005;
        rom[6] = 32'h0800_0004;  // J 4 -> byte 16
        rom[7] = 32'h2007_0007;
        rom[1023] = 32'h2009_0009;

        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        step(); step();

        // Reset state
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_pc",    ifid_pc, 32'h0);
        chk("rst_pc4",   ifid_pc_plus4, 32'h0);
        chk("rst_fault", {31'h0, fetch_fault}, 32'h0);

        // Sequential fetch
        rst_n = 1'b1;
        step(); chk_ifid("seq0", 32'd0, 32'h8c01_0001, 32'd4);
        step(); chk_ifid("seq1", 32'd4, 32'h8c02_0002, 32'd8);
        step(); chk_ifid("seq2", 32'd8, 32'h0022_1820, 32'd12);

        // Stall for three clocks
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_ifid("stall", 32'd8, 32'h0022_1820, 32'd12);
        end
        stall = 1'b0;
        step(); chk_ifid("resume", 32'd12, 32'hac03_0003, 32'd16);

        // Early J at word 6
        step(); chk_ifid("seq4", 32'd16, 32'h2004_0004, 32'd20);
        step(); chk_ifid("seq5", 32'd20, 32'h2005_0005, 32'd24);
        step(); chk_ifid("jump", 32'd24, 32'h0800_0004, 32'd16);
        step(); chk_ifid("jdst", 32'd16, 32'h2004_0004, 32'd20);
        step(); chk_ifid("jnext", 32'd20, 32'h2005_0005, 32'd24);

        // J under stall is ignored; redirect overrides stall
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'd28;
        step();
        chk("redir_addr",  imem_addr, 32'd28);
        chk("redir_valid", {31'h0, ifid_valid}, 32'h0);
        stall = 1'b0; redirect_valid = 1'b0;
        step(); chk_ifid("redir_tgt", 32'd28, 32'h2007_0007, 32'd32);

        // Misaligned redirect target -> fault on following cycle
        redirect_valid = 1'b1; redirect_target = 32'h0000_1002;
        step();
        chk("mis_addr",  imem_addr, 32'h1002);
        chk("mis_fault0", {31'h0, fetch_fault}, 32'h0);
        redirect_valid = 1'b0;
        step();
        chk("mis_fault", {31'h0, fetch_fault}, 32'h1);
        chk("mis_valid", {31'h0, ifid_valid}, 32'h0);
        chk("mis_hold",  imem_addr, 32'h1002);
        // Fault is sticky and blocks redirects
        redirect_valid = 1'b1; redirect_target = 32'd0;
        step();
        redirect_valid = 1'b0;
        chk("flt_redir_addr",  imem_addr, 32'h1002);
        chk("flt_redir_fault", {31'h0, fetch_fault}, 32'h1);

        // Asynchronous reset mid-cycle during fault
        #2 rst_n = 1'b0;
        #1;
        chk("arst_addr",  imem_addr, 32'h0);
        chk("arst_fault", {31'h0, fetch_fault}, 32'h0);
        chk("arst_valid", {31'h0, ifid_valid}, 32'h0);
        chk("arst_pc",    ifid_pc, 32'h0);
        chk("arst_instr", ifid_instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Last legal word, then walk off the end of memory
        redirect_valid = 1'b1; redirect_target = 32'h0000_0FFC;
        step();
        redirect_valid = 1'b0;
        step(); chk_ifid("last", 32'h0000_0FFC, 32'h2009_0009, 32'h0000_1000);
        chk("last_fault", {31'h0, fetch_fault}, 32'h0);
        step();
        chk("oor_fault", {31'h0, fetch_fault}, 32'h1);
        chk("oor_valid", {31'h0, ifid_valid}, 32'h0);
        chk("oor_addr",  imem_addr, 32'h0000_1000);

        // Direct redirect to the first out-of-range address
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h0000_1000;
        step();
        redirect_valid = 1'b0;
        chk("oor2_fault0", {31'h0, fetch_fault}, 32'h0);
        step();
        chk("oor2_fault", {31'h0, fetch_fault}, 32'h1);
        chk("oor2_addr",  imem_addr, 32'h0000_1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
